// File: rtl/tlc_phase_arbiter.sv
// Intersection phase arbiter: highway holds by default, farm road and pedestrian
// requests are latched and granted round-robin with min/max green and clearance timing.
module tlc_phase_arbiter #(
  parameter int unsigned T_HWY_MIN  = 1500000000,
  parameter int unsigned T_YEL      = 150000000,
  parameter int unsigned T_ALLRED   = 50000000,
  parameter int unsigned T_FARM_MIN = 150000000,
  parameter int unsigned T_FARM_MAX = 750000000,
  parameter int unsigned T_WALK     = 750000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmSensor,
  input  logic       pedButton,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       walk,
  output logic [2:0] state,
  output logic       farmPending,
  output logic       pedPending
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    HWY_G  = 3'd1,
    HWY_Y  = 3'd2,
    AR1    = 3'd3,
    FARM_G = 3'd4,
    FARM_Y = 3'd5,
    WALK   = 3'd6,
    AR2    = 3'd7
  } phase_t;

  localparam logic [30:0] HWY_LAST  = 31'(T_HWY_MIN - 1);
  localparam logic [30:0] YEL_LAST  = 31'(T_YEL - 1);
  localparam logic [30:0] AR_LAST   = 31'(T_ALLRED - 1);
  localparam logic [30:0] FMIN_LAST = 31'(T_FARM_MIN - 1);
  localparam logic [30:0] FMAX_LAST = 31'(T_FARM_MAX - 1);
  localparam logic [30:0] WALK_LAST = 31'(T_WALK - 1);

  phase_t      cur, nxt;
  logic [30:0] cnt;
  logic        lastSide;
  logic        grantFarm;

  // On a tie the side not served last wins; lastSide=1 means walk went last.
  assign grantFarm = ~pedPending | (farmPending & lastSide);

  always_comb begin
    nxt = cur;
    case (cur)
      INIT:   if (cnt == AR_LAST) nxt = HWY_G;
      HWY_G:  if (cnt >= HWY_LAST && (farmPending || pedPending)) nxt = HWY_Y;
      HWY_Y:  if (cnt == YEL_LAST) nxt = AR1;
      AR1:    if (cnt == AR_LAST) nxt = grantFarm ? FARM_G : WALK;
      FARM_G: if ((cnt >= FMIN_LAST && !farmSensor) || cnt == FMAX_LAST) nxt = FARM_Y;
      FARM_Y: if (cnt == YEL_LAST) nxt = AR2;
      WALK:   if (cnt == WALK_LAST) nxt = AR2;
      AR2:    if (cnt == AR_LAST) nxt = HWY_G;
      default: nxt = INIT;
    endcase
  end

  always_comb begin
    highwaySignal = 2'b00;
    farmSignal    = 2'b00;
    walk          = 1'b0;
    case (cur)
      HWY_G:  highwaySignal = 2'b11;
      HWY_Y:  highwaySignal = 2'b10;
      FARM_G: farmSignal    = 2'b11;
      FARM_Y: farmSignal    = 2'b10;
      WALK:   walk          = 1'b1;
      default: ;
    endcase
  end

  // Request latches clear on the edge that enters their phase, so clear beats set.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cur         <= INIT;
      cnt         <= '0;
      farmPending <= 1'b0;
      pedPending  <= 1'b0;
      lastSide    <= 1'b1;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        cnt <= '0;
      else if (cur == HWY_G && cnt >= HWY_LAST)
        cnt <= cnt;
      else
        cnt <= cnt + 31'd1;

      if (nxt == FARM_G)
        farmPending <= 1'b0;
      else if (farmSensor && cur != FARM_G)
        farmPending <= 1'b1;

      if (nxt == WALK)
        pedPending <= 1'b0;
      else if (pedButton && cur != WALK)
        pedPending <= 1'b1;

      if (nxt == FARM_G && cur != FARM_G)
        lastSide <= 1'b0;
      else if (nxt == WALK && cur != WALK)
        lastSide <= 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Directed bench for tlc_phase_arbiter: vector table for reset/idle/request latching,
// hand-written sequences for phase durations, arbitration and mid-phase reset.
module tb_tlc_phase_arbiter;

  localparam int unsigned P_HWY_MIN  = 20;
  localparam int unsigned P_YEL      = 3;
  localparam int unsigned P_ALLRED   = 2;
  localparam int unsigned P_FARM_MIN = 5;
  localparam int unsigned P_FARM_MAX = 10;
  localparam int unsigned P_WALK     = 8;

  localparam logic [2:0] S_INIT = 3'd0, S_HWY_G = 3'd1, S_HWY_Y = 3'd2, S_AR1 = 3'd3,
                         S_FARM_G = 3'd4, S_FARM_Y = 3'd5, S_WALK = 3'd6, S_AR2 = 3'd7;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       farmSensor = 1'b0;
  logic       pedButton = 1'b0;
  logic [1:0] highwaySignal, farmSignal;
  logic       walk;
  logic [2:0] state;
  logic       farmPending, pedPending;

  int total = 0;
  int bad = 0;

  tlc_phase_arbiter #(
    .T_HWY_MIN(P_HWY_MIN), .T_YEL(P_YEL), .T_ALLRED(P_ALLRED),
    .T_FARM_MIN(P_FARM_MIN), .T_FARM_MAX(P_FARM_MAX), .T_WALK(P_WALK)
  ) dut (
    .Clk(Clk), .Rst(Rst), .farmSensor(farmSensor), .pedButton(pedButton),
    .highwaySignal(highwaySignal), .farmSignal(farmSignal), .walk(walk),
    .state(state), .farmPending(farmPending), .pedPending(pedPending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       farm;
    logic       ped;
    int         ticks;
    logic [2:0] st;
    logic [1:0] hw;
    logic [1:0] fm;
    logic       wk;
    logic       fp;
    logic       pp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic p);
    Rst = r;
    farmSensor = f;
    pedButton = p;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic [1:0] hw,
                             input logic [1:0] fm, input logic wk, input logic fp, input logic pp);
    check({name, "_state"}, 32'(state), 32'(st));
    check({name, "_lamps"}, 32'({highwaySignal, farmSignal, walk}), 32'({hw, fm, wk}));
    check({name, "_pend"}, 32'({farmPending, pedPending}), 32'({fp, pp}));
  endtask

  function automatic logic [4:0] lampsFor(input logic [2:0] s);
    case (s)
      S_HWY_G:  return 5'b11_00_0;
      S_HWY_Y:  return 5'b10_00_0;
      S_FARM_G: return 5'b00_11_0;
      S_FARM_Y: return 5'b00_10_0;
      S_WALK:   return 5'b00_00_1;
      default:  return 5'b00_00_0;
    endcase
  endfunction

  // Called in the first observed cycle of a phase; counts cycles until it is left.
  task automatic expectPhase(input string name, input logic [2:0] st, input int dur);
    int n;
    check({name, "_entry"}, 32'(state), 32'(st));
    if (state == st) begin
      check({name, "_lamps"}, 32'({highwaySignal, farmSignal, walk}), 32'(lampsFor(st)));
      n = 0;
      while (state == st && n < dur + 5) begin
        tick();
        n++;
      end
      check({name, "_len"}, 32'(n), 32'(dur));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2,   S_INIT,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1,   S_INIT,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1,   S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 200, S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1,   S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1,   S_HWY_Y, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0};

    // Reset, idle highway hold, one-cycle farm pulse ending highway green.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].farm, vecs[i].ped);
      repeat (vecs[i].ticks) tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].hw, vecs[i].fm,
                  vecs[i].wk, vecs[i].fp, vecs[i].pp);
    end

    // Pulsed farm request gets minimum farm green.
    expectPhase("t3_hwyY", S_HWY_Y, 3);
    expectPhase("t3_ar1", S_AR1, 2);
    checkOutput("t3_farmEntry", S_FARM_G, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    expectPhase("t3_farmG", S_FARM_G, 5);
    expectPhase("t3_farmY", S_FARM_Y, 3);
    expectPhase("t3_ar2", S_AR2, 2);

    // Held farm request from highway cycle 5 runs farm green to its maximum.
    check("t2_hwyEntry", 32'(state), 32'(S_HWY_G));
    repeat (5) tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectPhase("t2_hwyG", S_HWY_G, 15);
    expectPhase("t2_hwyY", S_HWY_Y, 3);
    expectPhase("t2_ar1", S_AR1, 2);
    checkOutput("t2_farmEntry", S_FARM_G, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    expectPhase("t2_farmG", S_FARM_G, 10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectPhase("t2_farmY", S_FARM_Y, 3);
    expectPhase("t2_ar2", S_AR2, 2);
    repeat (30) tick();
    checkOutput("t2_idle", S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);

    // Tie after reset goes to farm, then sides alternate.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check("t4_hwyEntry", 32'(state), 32'(S_HWY_G));
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_bothLatched", S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
    expectPhase("t4_hwyG1", S_HWY_G, 19);
    expectPhase("t4_hwyY1", S_HWY_Y, 3);
    expectPhase("t4_ar1a", S_AR1, 2);
    checkOutput("t4_tieFarm", S_FARM_G, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    expectPhase("t4_farmG1", S_FARM_G, 5);
    expectPhase("t4_farmY1", S_FARM_Y, 3);
    expectPhase("t4_ar2a", S_AR2, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectPhase("t4_hwyG2", S_HWY_G, 19);
    expectPhase("t4_hwyY2", S_HWY_Y, 3);
    expectPhase("t4_ar1b", S_AR1, 2);
    checkOutput("t4_tieWalk", S_WALK, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);

    // Button pressed during walk is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_pedInWalk", S_WALK, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    expectPhase("t4_walk1", S_WALK, 7);
    expectPhase("t4_ar2b", S_AR2, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_bothAgain", S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
    expectPhase("t4_hwyG3", S_HWY_G, 19);
    expectPhase("t4_hwyY3", S_HWY_Y, 3);
    expectPhase("t4_ar1c", S_AR1, 2);
    checkOutput("t4_tieFarm2", S_FARM_G, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    expectPhase("t4_farmG2", S_FARM_G, 5);
    expectPhase("t4_farmY2", S_FARM_Y, 3);
    expectPhase("t4_ar2c", S_AR2, 2);
    expectPhase("t4_hwyG4", S_HWY_G, 20);
    expectPhase("t4_hwyY4", S_HWY_Y, 3);
    expectPhase("t4_ar1d", S_AR1, 2);
    expectPhase("t4_walk2", S_WALK, 8);
    expectPhase("t4_ar2d", S_AR2, 2);
    repeat (100) tick();
    checkOutput("t5_hold", S_HWY_G, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset in farm green cycle 3 aborts straight to INIT.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    expectPhase("t6_hwyY", S_HWY_Y, 3);
    expectPhase("t6_ar1", S_AR1, 2);
    check("t6_farmEntry", 32'(state), 32'(S_FARM_G));
    repeat (3) tick();
    check("t6_farmCycle3", 32'(state), 32'(S_FARM_G));
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t6_reset", S_INIT, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t6_noYellow", S_INIT, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlc_phase_arbiter.md
# tlc_phase_arbiter

Intersection phase arbiter for the highway/farm-road traffic light controller. Highway traffic holds the road by default. The block shares the intersection between two requesters: a farm-road vehicle sensor and a pedestrian push-button. It enforces minimum and maximum green times, yellow and all-red clearance, and round-robin fairness, using its own internal 31-bit phase timer. It drives the lamp outputs directly and replaces the external count/reset-count handshake.

## Interface
- T_HWY_MIN, 1500000000, minimum highway green in cycles (30 s @ 50 MHz)
- T_YEL, 150000000, yellow duration in cycles (3 s)
- T_ALLRED, 50000000, all-red clearance in cycles (1 s)
- T_FARM_MIN, 150000000, minimum farm green in cycles (3 s)
- T_FARM_MAX, 750000000, maximum farm green in cycles (15 s)
- T_WALK, 750000000, pedestrian walk duration in cycles (15 s)
- Clk  input  1  system clock; all logic on posedge
- Rst  input  1  synchronous, active-high reset
- farmSensor  input  1  farm-road vehicle present, level
- pedButton  input  1  pedestrian request, any-cycle pulse or level
- highwaySignal  output  2  highway lamp: 11 green, 10 yellow, 00 red
- farmSignal  output  2  farm lamp, same encoding
- walk  output  1  pedestrian walk lamp
- state  output  3  current phase, for debug
- farmPending, pedPending  output  1 each  latched request flags

## Operation
- Phases (state encoding):
  - INIT=0: all red.
  - HWY_G=1: highway green.
  - HWY_Y=2: highway yellow.
  - AR1=3: all red.
  - FARM_G=4: farm green.
  - FARM_Y=5: farm yellow.
  - WALK=6: all red, walk=1.
  - AR2=7: all red.
- Lamps and walk are a Moore decode of `state`. In every non-green, non-yellow phase both lamps are 00. walk=1 only in WALK.
- Phase timer `cnt` is 31 bits. It is 0 in the first cycle of each phase and increments by 1 per cycle. Every timed exit fires when cnt == T-1, so a phase lasts exactly T cycles.
- Transitions:
  - INIT → HWY_G after T_ALLRED.
  - HWY_G: once cnt ≥ T_HWY_MIN-1 and (farmPending | pedPending) → HWY_Y. Highway holds indefinitely with no request.
  - HWY_Y → AR1 after T_YEL.
  - AR1 → FARM_G or WALK after T_ALLRED, per the grant rule below.
  - FARM_G exits to FARM_Y when:
    - cnt ≥ T_FARM_MIN-1 and farmSensor=0, or
    - cnt == T_FARM_MAX-1, regardless of farmSensor.
  - FARM_Y → AR2 after T_YEL.
  - WALK → AR2 after T_WALK.
  - AR2 → HWY_G after T_ALLRED. Highway is always served between side phases.
- Grant rule at AR1 exit:
  - Only farmPending set → FARM_G.
  - Only pedPending set → WALK.
  - Both set → the requester not served last; the internal `lastSide` bit records this.
  - `lastSide` updates on entry to FARM_G (0) or WALK (1). Its reset value is 1, so farm wins the first tie.
- Request latches:
  - farmPending is set in any cycle farmSensor=1, except while in FARM_G. It is cleared in the first cycle of FARM_G.
  - pedPending is set in any cycle pedButton=1, except while in WALK. It is cleared in the first cycle of WALK.
  - A request asserted in the same cycle the phase is entered is dropped; clear wins.
- A request that arrives during HWY_Y or AR1 is still considered at AR1 exit.

## Timing
- Reset (Rst=1 at posedge):
  - state=INIT, cnt=0, farmPending=0, pedPending=0, lastSide=1.
  - Lamps 00/00, walk=0.
  - Reset mid-phase aborts immediately; no yellow is generated.
- Outputs change in the same cycle `state` changes; there is zero decode latency after the clock edge.
- Latches are registered. A request seen at edge k can cause the HWY_G→HWY_Y exit at edge k+1 at the earliest.
- cnt never wraps: every phase exit is reached before cnt would overflow 31 bits. HWY_G saturates cnt at T_HWY_MIN-1 while idle.
- Parameter constraints:
  - All T ≥ 1.
  - T_FARM_MIN ≤ T_FARM_MAX.
  - All T < 2^31.
  - Out-of-range values are unsupported.

## Test plan
Bench overrides: T_HWY_MIN=20, T_YEL=3, T_ALLRED=2, T_FARM_MIN=5, T_FARM_MAX=10, T_WALK=8.

1. Rst for 2 cycles, then release with no requests → INIT for 2 cycles, then HWY_G held for 200+ cycles. Lamps 00/00 then 11/00; walk=0 throughout.
2. farmSensor=1 at HWY_G cycle 5 and held → HWY_G lasts 20 cycles, HWY_Y 3, AR1 2. FARM_G lasts exactly 10 cycles (max). Then FARM_Y 3, AR2 2, back to HWY_G. farmPending reads 0 in the first FARM_G cycle.
3. farmSensor pulse for 1 cycle during HWY_G → FARM_G lasts exactly 5 cycles (min).
4. Both pedButton and farmSensor pulsed during HWY_G after reset → FARM_G is served first. After the next HWY_G minimum, WALK is served for 8 cycles with walk=1 and lamps 00/00. Farm and pedestrian then alternate while both are re-requested.
5. pedButton pulsed during WALK → ignored; pedPending stays 0. Highway then holds indefinitely.
6. Rst asserted in FARM_G cycle 3 → next cycle state=INIT, lamps 00/00, both pending flags 0, with no intervening FARM_Y.
